dct_prod_accum: RTL and testbench
=================================

// Module: dct_prod_accum
// PURPOSE
//  Downstream of the 8-stage signed 11x8 product pipeline in the DCT datapath: sums N_TERMS
//  consecutive 19-bit signed products (CX*CT) into one DCT coefficient.
//  Rounds, scales and saturates each sum to OUT_W bits, and tags it with its coefficient index.
//  Input is a streaming valid-qualified interface; the caller delays the valid to match product latency.
// PARAMETERS
//  IN_W     19  product width, two's complement
//  N_TERMS   8  products summed per coefficient (power of 2, >=2)
//  N_COEF    8  coefficients per block (power of 2); coef_idx wraps after N_COEF-1
//  SHIFT     8  fractional bits dropped by rounding (>=1)
//  OUT_W    12  coefficient output width, two's complement
//  ACC_W = IN_W + log2(N_TERMS) (22 at defaults) is derived; the accumulator cannot overflow.
// PORTS
//  clk         in   1               rising-edge clock
//  rst         in   1               synchronous reset, active-high
//  sync_clr    in   1               restart term/coef counters, clear sat_flag
//  prod_valid  in   1               prod is valid this cycle
//  prod        in   IN_W            signed product from multiplier
//  coef_valid  out  1               one-cycle pulse: coef/coef_idx valid
//  coef        out  OUT_W           signed rounded, saturated coefficient
//  coef_idx    out  log2(N_COEF)    index of coef within block
//  block_done  out  1               pulses with coef_valid when coef_idx==N_COEF-1
//  sat_flag    out  1               sticky: some coef was saturated
// BEHAVIOUR
//  Reset (rst=1 at clk edge): acc, term_cnt, coef_cnt, coef, coef_idx = 0; coef_valid, block_done,
//   sat_flag = 0. Reset mid-block discards the partial sum; no output is produced for it.
//  Accumulation (prod_valid=1):
//   - term_cnt==0: acc <= sext(prod); else acc <= acc + sext(prod). term_cnt++.
//   - term_cnt==N_TERMS-1: sum = acc + sext(prod) is finalised; term_cnt <= 0; acc not reused.
//  prod_valid=0: acc, term_cnt hold; gaps of any length allowed between terms.
//  Final stage, from sum:
//   - r = (sum + 2^(SHIFT-1)) >>> SHIFT, computed in ACC_W+1 bits (round half up).
//   - r > 2^(OUT_W-1)-1 -> coef = 2^(OUT_W-1)-1; r < -2^(OUT_W-1) -> coef = -2^(OUT_W-1);
//     sat_flag <= 1 on either case; otherwise coef = r[OUT_W-1:0].
//  Latency: coef_valid=1 exactly one cycle after the edge accepting the N_TERMS-th product.
//   coef_idx = coef_cnt at that time; coef_cnt then increments and wraps N_COEF-1 -> 0.
//   block_done = coef_valid & (coef_idx==N_COEF-1).
//   coef and coef_idx hold between pulses; coef_valid and block_done are 0 otherwise.
//  Back-to-back: a product for the next coefficient may arrive the cycle after the last term.
//   Full throughput is one product per clock, i.e. one coef every N_TERMS cycles.
//  sync_clr=1:
//   - term_cnt and coef_cnt are cleared and sat_flag <= 0.
//   - If prod_valid=1 the same cycle, that product is term 0 of coef 0 (acc <= sext(prod)).
//   - If a final sum completes the same cycle, its coef_valid pulse is suppressed.
//  rst has priority over sync_clr; sync_clr has priority over normal accumulation.
//  No backpressure: the consumer takes coef on the coef_valid cycle.
// TESTING
//  1 rst; 8 valid prods of +100 -> sum 800, coef_valid 1 cycle after 8th, coef=3, coef_idx=0, sat_flag=0
//  2 8 prods of -100 -> sum -800, coef=-3 (floor(-672/256)); prods 0 -> coef=0
//  3 8 prods of +262143 -> coef=+2047, sat_flag=1; 8 of -262144 -> coef=-2048; sat_flag stays 1 until sync_clr
//  4 64 back-to-back prods (+256 each) -> 8 coef_valid pulses every 8 cycles, coef=8, idx 0..7, block_done on idx 7
//  5 same stream with random 0-5 cycle prod_valid gaps -> identical coef/idx sequence to case 4
//  6 rst after 5 terms, then 8 terms of +512 -> single coef=16, idx=0; repeat with sync_clr on a valid cycle
//    -> that prod counts as term 0

Source files
------------

// File: rtl/dct_prod_accum.sv
// Sums N_TERMS signed products into one DCT coefficient.
// Each sum is rounded half-up, scaled by 2^-SHIFT, saturated to OUT_W bits and tagged with its index.
module dct_prod_accum #(
    parameter int IN_W    = 19,
    parameter int N_TERMS = 8,
    parameter int N_COEF  = 8,
    parameter int SHIFT   = 8,
    parameter int OUT_W   = 12,
    localparam int TERM_W = $clog2(N_TERMS),
    localparam int IDX_W  = (N_COEF > 1) ? $clog2(N_COEF) : 1,
    localparam int ACC_W  = IN_W + TERM_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_clr,
    input  logic             prod_valid,
    input  logic [IN_W-1:0]  prod,
    output logic             coef_valid,
    output logic [OUT_W-1:0] coef,
    output logic [IDX_W-1:0] coef_idx,
    output logic             block_done,
    output logic             sat_flag
);

    localparam logic [ACC_W:0]        RND   = {{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [ACC_W:0] MAX_C = (ACC_W + 1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W:0] MIN_C = ~MAX_C;
    localparam logic [TERM_W-1:0]     LAST_TERM = TERM_W'(N_TERMS - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(N_COEF - 1);

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [TERM_W-1:0] term_cnt_q, term_cnt_d;
    logic [IDX_W-1:0]  coef_cnt_q, coef_cnt_d;
    logic [OUT_W-1:0]  coef_q, coef_d;
    logic [IDX_W-1:0]  coef_idx_q, coef_idx_d;
    logic              coef_valid_q, coef_valid_d;
    logic              block_done_q, block_done_d;
    logic              sat_flag_q, sat_flag_d;

    logic [ACC_W-1:0]        prod_ext;
    logic [ACC_W-1:0]        sum_c;
    logic signed [ACC_W:0]   rnd_wide;
    logic signed [ACC_W:0]   r_c;
    logic                    sat_hi, sat_lo;
    logic [OUT_W-1:0]        coef_sat;

    // Rounding path: one extra bit of headroom so the +half never wraps.
    always_comb begin
        prod_ext = {{TERM_W{prod[IN_W-1]}}, prod};
        sum_c    = (term_cnt_q == '0) ? prod_ext : acc_q + prod_ext;
        rnd_wide = $signed({sum_c[ACC_W-1], sum_c} + RND);
        r_c      = rnd_wide >>> SHIFT;
        sat_hi   = (r_c > MAX_C);
        sat_lo   = (r_c < MIN_C);
        if (sat_hi) begin
            coef_sat = MAX_C[OUT_W-1:0];
        end else if (sat_lo) begin
            coef_sat = MIN_C[OUT_W-1:0];
        end else begin
            coef_sat = r_c[OUT_W-1:0];
        end
    end

    always_comb begin
        acc_d        = acc_q;
        term_cnt_d   = term_cnt_q;
        coef_cnt_d   = coef_cnt_q;
        coef_d       = coef_q;
        coef_idx_d   = coef_idx_q;
        coef_valid_d = 1'b0;
        block_done_d = 1'b0;
        sat_flag_d   = sat_flag_q;

        if (sync_clr) begin
            // Any partial or just-completed sum is dropped; a coincident product starts coef 0.
            term_cnt_d = '0;
            coef_cnt_d = '0;
            sat_flag_d = 1'b0;
            if (prod_valid) begin
                acc_d      = prod_ext;
                term_cnt_d = TERM_W'(1);
            end
        end else if (prod_valid) begin
            acc_d = sum_c;
            if (term_cnt_q == LAST_TERM) begin
                term_cnt_d   = '0;
                coef_d       = coef_sat;
                coef_idx_d   = coef_cnt_q;
                coef_valid_d = 1'b1;
                block_done_d = (coef_cnt_q == LAST_IDX);
                coef_cnt_d   = coef_cnt_q + IDX_W'(1);
                sat_flag_d   = sat_flag_q | sat_hi | sat_lo;
            end else begin
                term_cnt_d = term_cnt_q + TERM_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            term_cnt_q   <= '0;
            coef_cnt_q   <= '0;
            coef_q       <= '0;
            coef_idx_q   <= '0;
            coef_valid_q <= 1'b0;
            block_done_q <= 1'b0;
            sat_flag_q   <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            term_cnt_q   <= term_cnt_d;
            coef_cnt_q   <= coef_cnt_d;
            coef_q       <= coef_d;
            coef_idx_q   <= coef_idx_d;
            coef_valid_q <= coef_valid_d;
            block_done_q <= block_done_d;
            sat_flag_q   <= sat_flag_d;
        end
    end

    assign coef_valid = coef_valid_q;
    assign coef       = coef_q;
    assign coef_idx   = coef_idx_q;
    assign block_done = block_done_q;
    assign sat_flag   = sat_flag_q;

endmodule

// File: tb/tb_dct_prod_accum.sv
// Bench for dct_prod_accum: cycle-accurate reference model plus a table of hand-derived blocks.
module tb_dct_prod_accum;

    localparam int IN_W = 19;
    localparam int N_TERMS = 8;
    localparam int N_COEF = 8;
    localparam int SHIFT = 8;
    localparam int OUT_W = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sync_clr = 1'b0;
    logic              prod_valid = 1'b0;
    logic [IN_W-1:0]   prod = '0;
    logic              coef_valid;
    logic [OUT_W-1:0]  coef;
    logic [2:0]        coef_idx;
    logic              block_done;
    logic              sat_flag;

    dct_prod_accum #(
        .IN_W(IN_W), .N_TERMS(N_TERMS), .N_COEF(N_COEF), .SHIFT(SHIFT), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst(rst), .sync_clr(sync_clr), .prod_valid(prod_valid), .prod(prod),
        .coef_valid(coef_valid), .coef(coef), .coef_idx(coef_idx),
        .block_done(block_done), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: list of pending terms, running coefficient index, sticky flag.
    longint m_terms[$];
    int     m_idx = 0;
    bit     m_sat = 0;
    longint m_coef = 0;
    int     m_last_idx = 0;

    longint dut_log[$];
    bit     logging = 0;

    typedef struct {
        int prod;
        int exp_coef;
        bit exp_sat;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint round_sat(input longint s, output bit sat);
        longint r;
        longint hi;
        longint lo;
        r  = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -(longint'(1) <<< (OUT_W - 1));
        sat = 0;
        if (r > hi) begin r = hi; sat = 1; end
        if (r < lo) begin r = lo; sat = 1; end
        return r;
    endfunction

    // One clock: apply inputs, advance the model, compare every output after the edge.
    task automatic drive(input bit v, input int p, input bit c, input bit r);
        bit     exp_v;
        bit     exp_bd;
        bit     s;
        longint sum;
        exp_v  = 0;
        exp_bd = 0;
        prod_valid = v;
        prod       = p[IN_W-1:0];
        sync_clr   = c;
        rst        = r;
        if (r) begin
            m_terms.delete(); m_idx = 0; m_sat = 0; m_coef = 0; m_last_idx = 0;
        end else if (c) begin
            m_terms.delete(); m_idx = 0; m_sat = 0;
            if (v) m_terms.push_back(longint'(p));
        end else if (v) begin
            m_terms.push_back(longint'(p));
            if (m_terms.size() == N_TERMS) begin
                sum = 0;
                foreach (m_terms[k]) sum += m_terms[k];
                m_coef = round_sat(sum, s);
                if (s) m_sat = 1;
                m_last_idx = m_idx;
                exp_v  = 1;
                exp_bd = (m_idx == N_COEF - 1);
                m_idx  = (m_idx + 1) % N_COEF;
                m_terms.delete();
            end
        end
        @(posedge clk);
        #1;
        check("coef_valid", coef_valid, exp_v);
        check("block_done", block_done, exp_bd);
        check("coef", $signed(coef), m_coef);
        check("coef_idx", coef_idx, m_last_idx);
        check("sat_flag", sat_flag, m_sat);
        if (logging && coef_valid) dut_log.push_back(longint'($signed(coef)) * 16 + coef_idx);
    endtask

    task automatic send_block(input int p);
        for (int k = 0; k < N_TERMS; k++) drive(1, p, 0, 0);
    endtask

    function automatic int rand_prod();
        return int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W - 1));
    endfunction

    initial begin
        longint ref_log[$];
        int gap;

        tbl[0] = '{prod: 100,     exp_coef: 3,     exp_sat: 0};
        tbl[1] = '{prod: -100,    exp_coef: -3,    exp_sat: 0};
        tbl[2] = '{prod: 0,       exp_coef: 0,     exp_sat: 0};
        tbl[3] = '{prod: 16,      exp_coef: 1,     exp_sat: 0};
        tbl[4] = '{prod: -16,     exp_coef: 0,     exp_sat: 0};
        tbl[5] = '{prod: 65504,   exp_coef: 2047,  exp_sat: 0};
        tbl[6] = '{prod: -65536,  exp_coef: -2048, exp_sat: 0};
        tbl[7] = '{prod: 262143,  exp_coef: 2047,  exp_sat: 1};
        tbl[8] = '{prod: -262144, exp_coef: -2048, exp_sat: 1};
        tbl[9] = '{prod: 65536,   exp_coef: 2047,  exp_sat: 1};

        drive(0, 0, 0, 1);
        drive(0, 0, 0, 1);
        check("reset_coef", $signed(coef), 0);
        check("reset_valid", coef_valid, 0);

        // Fixed-value blocks with hand-derived results, coefficient index advancing.
        for (int i = 0; i < 10; i++) begin
            send_block(tbl[i].prod);
            check("tbl_valid", coef_valid, 1);
            check("tbl_coef", $signed(coef), tbl[i].exp_coef);
            check("tbl_idx", coef_idx, i % N_COEF);
            check("tbl_sat", sat_flag, tbl[i].exp_sat);
            drive(0, 0, 0, 0);
            check("tbl_hold_coef", $signed(coef), tbl[i].exp_coef);
        end
        drive(0, 0, 0, 0);
        check("sat_sticky", sat_flag, 1);
        drive(0, 0, 1, 0);
        check("sat_cleared", sat_flag, 0);

        // Back-to-back stream, logged for comparison with the gapped run.
        logging = 1;
        for (int k = 0; k < 64; k++) drive(1, 256, 0, 0);
        drive(0, 0, 0, 0);
        logging = 0;
        check("b2b_count", dut_log.size(), 8);
        ref_log = dut_log;
        dut_log.delete();

        drive(0, 0, 1, 0);
        logging = 1;
        for (int k = 0; k < 64; k++) begin
            gap = int'($urandom_range(0, 5));
            for (int g = 0; g < gap; g++) drive(0, rand_prod(), 0, 0);
            drive(1, 256, 0, 0);
        end
        drive(0, 0, 0, 0);
        logging = 0;
        check("gap_count", dut_log.size(), ref_log.size());
        for (int k = 0; k < ref_log.size() && k < dut_log.size(); k++)
            check("gap_seq", dut_log[k], ref_log[k]);
        check("gap_expect_last", ref_log.size() > 0 ? ref_log[ref_log.size()-1] : 0, 8 * 16 + 7);

        // Reset mid-block discards the partial sum.
        for (int k = 0; k < 5; k++) drive(1, 1000, 0, 0);
        drive(0, 0, 0, 1);
        send_block(512);
        check("rst_mid_coef", $signed(coef), 16);
        check("rst_mid_idx", coef_idx, 0);

        // sync_clr on a valid cycle: that product is term 0.
        for (int k = 0; k < 5; k++) drive(1, 3000, 0, 0);
        drive(1, 512, 1, 0);
        for (int k = 0; k < 7; k++) drive(1, 512, 0, 0);
        check("clr_valid_coef", $signed(coef), 16);
        check("clr_valid_idx", coef_idx, 0);

        // sync_clr coincident with a completing term suppresses the pulse.
        for (int k = 0; k < 7; k++) drive(1, 512, 0, 0);
        drive(1, 512, 1, 0);
        check("clr_suppress", coef_valid, 0);
        for (int k = 0; k < 7; k++) drive(1, 512, 0, 0);
        check("clr_after_idx", coef_idx, 0);

        // Randomised traffic against the model.
        for (int k = 0; k < 600; k++) begin
            drive($urandom_range(0, 3) != 0, rand_prod(),
                  $urandom_range(0, 59) == 0, $urandom_range(0, 299) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
